dense_update_ctrl: RTL

DENSE_UPDATE_CTRL -- requirements
Module: dense_update_ctrl

---
 rtl/dense_update_ctrl_if.sv | 21 ++
 rtl/dense_update_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/dense_update_ctrl_if.sv
// dense_update_ctrl_if -- request/response bundle for the dense weight updater.
//   start      : request one update pass (master -> slave)
//   weight_in  : packed current weights, element i at [i*data_size +: data_size]
//   diff_in    : packed gradient vector, same packing
//   weight_out : packed updated weights (slave -> master)
//   busy       : pass in progress (capture / update)
//   done       : one-cycle pulse when weight_out has just been committed
interface dense_update_ctrl_if #(
  parameter int size      = 3,
  parameter int data_size = 16
);
  logic                      start;
  logic [size*data_size-1:0] weight_in;
  logic [size*data_size-1:0] diff_in;
  logic [size*data_size-1:0] weight_out;
  logic                      busy;
  logic                      done;

  modport master (output start, weight_in, diff_in, input weight_out, busy, done);
  modport slave  (input start, weight_in, diff_in, output weight_out, busy, done);
endinterface

// File: rtl/dense_update_ctrl.sv
// dense_update_ctrl -- SGD-style weight update, one element per cycle:
//   w[i] = sat(w[i] - (d[i] >>> lr_shift))
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : dense_update_ctrl_if slave (start/weight_in/diff_in in,
//           weight_out/busy/done out)
// Flow: IDLE -start-> CAPTURE (inputs latched on entry) -> UPDATE x size
//       -> DONE (weight_out committed on entry, done pulses) -> IDLE.
module dense_update_ctrl #(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int lr_shift  = 2
) (
  input logic             clk,
  input logic             reset,
  dense_update_ctrl_if.slave bus
);
  localparam int IW = (size > 1) ? $clog2(size) : 1;
  localparam logic signed [data_size-1:0] S_MAX = {1'b0, {(data_size-1){1'b1}}};
  localparam logic signed [data_size-1:0] S_MIN = {1'b1, {(data_size-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE, DONE} state_t;
  typedef logic [size-1:0][data_size-1:0] vec_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  vec_t          w_buf_q, w_buf_d;
  vec_t          d_buf_q, d_buf_d;
  vec_t          wout_q, wout_d;

  logic signed [data_size-1:0] w_cur, d_shf, w_new;
  logic signed [data_size:0]   sub;

  // Element datapath for the current index. One guard bit on the subtract;
  // disagreement between the top two bits means the true result left range.
  always_comb begin
    w_cur = w_buf_q[idx_q];
    d_shf = $signed(d_buf_q[idx_q]) >>> lr_shift;
    sub   = {w_cur[data_size-1], w_cur} - {d_shf[data_size-1], d_shf};
    if (sub[data_size] != sub[data_size-1])
      w_new = sub[data_size] ? S_MIN : S_MAX;
    else
      w_new = sub[data_size-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_buf_d = w_buf_q;
    d_buf_d = d_buf_q;
    wout_d  = wout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CAPTURE;
          w_buf_d = bus.weight_in;
          d_buf_d = bus.diff_in;
          idx_d   = '0;
        end
      end
      CAPTURE: state_d = UPDATE;
      UPDATE: begin
        w_buf_d[idx_q] = w_new;
        if (idx_q == IW'(size - 1)) begin
          state_d = DONE;
          idx_d   = '0;
          // Commit includes the element written this same cycle.
          wout_d  = w_buf_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      w_buf_q <= '0;
      d_buf_q <= '0;
      wout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_buf_q <= w_buf_d;
      d_buf_q <= d_buf_d;
      wout_q  <= wout_d;
    end
  end

  assign bus.weight_out = wout_q;
  assign bus.busy       = (state_q == CAPTURE) || (state_q == UPDATE);
  assign bus.done       = (state_q == DONE);
endmodule
